// File: rtl/alu_pkg.sv
// Shared op-codes and FSM state encoding for the EX-stage ALU / multiply-divide unit.
package alu_pkg;
  localparam logic [4:0] OP_AND  = 5'h00, OP_OR   = 5'h01, OP_ADD  = 5'h02, OP_SRA  = 5'h03;
  localparam logic [4:0] OP_SLL  = 5'h04, OP_SRL  = 5'h05, OP_SUB  = 5'h06, OP_SLT  = 5'h07;
  localparam logic [4:0] OP_ADDU = 5'h08, OP_SUBU = 5'h09, OP_SLTU = 5'h0A, OP_XOR  = 5'h0B;
  localparam logic [4:0] OP_NOR  = 5'h0C, OP_SRAV = 5'h0D, OP_SLLV = 5'h0E, OP_SRLV = 5'h0F;
  localparam logic [4:0] OP_MULT = 5'h10, OP_MULTU = 5'h11, OP_DIV = 5'h12, OP_DIVU = 5'h13;
  localparam logic [4:0] OP_MFHI = 5'h14, OP_MFLO = 5'h15, OP_MTHI = 5'h16, OP_MTLO = 5'h17;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/alu_mdu_if.sv
// Issue/result bundle between the EX-stage issuer and alu_mdu.
interface alu_mdu_if #(parameter int WIDTH = 32);
  logic             in_valid, in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             out_valid, zero, overflow;
  logic [WIDTH-1:0] res, hi, lo;

  modport master (output in_valid, op, a, b,
                  input  in_ready, out_valid, res, zero, overflow, hi, lo);
  modport slave  (input  in_valid, op, a, b,
                  output in_ready, out_valid, res, zero, overflow, hi, lo);
endinterface

// File: rtl/mdu_iter.sv
// Radix-2 iterative engine: shift-add multiply and restoring divide on magnitudes,
// with the sign fix-up applied to the step result so it can be written on the last step.
module mdu_iter import alu_pkg::*; #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   rem, acc, dv, rem_n, acc_n, mag_a, mag_b;
  logic [WIDTH:0]     sh, trial, sum;
  logic [2*WIDTH-1:0] prod;
  logic               div_q, neg_q, neg_r;

  assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;

  // rem always stays below the divisor, so the shifted trial fits in WIDTH+1 bits
  always_comb begin
    sh    = {rem, acc[WIDTH-1]};
    trial = sh - {1'b0, dv};
    sum   = {1'b0, rem} + (acc[0] ? {1'b0, dv} : '0);
    if (div_q) begin
      if (trial[WIDTH]) begin
        rem_n = sh[WIDTH-1:0];
        acc_n = {acc[WIDTH-2:0], 1'b0};
      end else begin
        rem_n = trial[WIDTH-1:0];
        acc_n = {acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      rem_n = sum[WIDTH:1];
      acc_n = {sum[0], acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod = neg_q ? -{rem_n, acc_n} : {rem_n, acc_n};
    if (div_q) begin
      lo_out = neg_q ? -acc_n : acc_n;
      hi_out = neg_r ? -rem_n : rem_n;
    end else begin
      lo_out = prod[WIDTH-1:0];
      hi_out = prod[2*WIDTH-1:WIDTH];
    end
  end

  assign done = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; rem <= '0; acc <= '0; dv <= '0;
      div_q <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0;
    end else if (start) begin
      cnt   <= CW'(WIDTH);
      rem   <= '0;
      acc   <= mag_a;
      dv    <= mag_b;
      div_q <= is_div;
      neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= sgn & a[WIDTH-1];
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      rem <= rem_n;
      acc <= acc_n;
    end
  end
endmodule

// File: rtl/alu_mdu.sv
// EX-stage unit: single-cycle ALU with registered result, HI/LO registers and the
// issue FSM that fronts the iterative multiply/divide engine.
module alu_mdu import alu_pkg::*; #(parameter int WIDTH = 32) (
  input logic        clk,
  input logic        rst,
  alu_mdu_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);

  state_t           state, state_n;
  logic             fire, is_iter, dz, start, done, big, alu_ov, ov_d, vld_d;
  logic             out_valid_q, zero_q, ov_q;
  logic [WIDTH-1:0] alu_r, sum, dif, res_d, hi_d, lo_d, hi_q, lo_q, res_q, hi_out, lo_out;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ov_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

  assign fire    = bus.in_valid & bus.in_ready;
  assign is_iter = (bus.op[4:2] == 3'b100);
  assign dz      = is_iter & bus.op[1] & (bus.b == '0);
  assign start   = fire & is_iter & ~dz;

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk), .rst(rst), .start(start), .is_div(bus.op[1]), .sgn(~bus.op[0]),
    .a(bus.a), .b(bus.b), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  // Shift amount is the full unsigned A; anything >= WIDTH saturates
  always_comb begin
    big    = |bus.a[WIDTH-1:SHW];
    sum    = bus.a + bus.b;
    dif    = bus.a - bus.b;
    alu_r  = '0;
    alu_ov = 1'b0;
    case (bus.op[3:0])
      4'h0:       alu_r = bus.a & bus.b;
      4'h1:       alu_r = bus.a | bus.b;
      4'h2, 4'h8: alu_r = sum;
      4'h6, 4'h9: alu_r = dif;
      4'h3, 4'hD: alu_r = big ? {WIDTH{bus.b[WIDTH-1]}} : ($signed(bus.b) >>> bus.a[SHW-1:0]);
      4'h4, 4'hE: alu_r = big ? '0 : (bus.b << bus.a[SHW-1:0]);
      4'h5, 4'hF: alu_r = big ? '0 : (bus.b >> bus.a[SHW-1:0]);
      4'h7:       alu_r = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'hA:       alu_r = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      4'hB:       alu_r = bus.a ^ bus.b;
      4'hC:       alu_r = ~(bus.a | bus.b);
    endcase
    if (bus.op[3:0] == 4'h2)
      alu_ov = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    else if (bus.op[3:0] == 4'h6)
      alu_ov = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
  end

  always_comb begin
    res_d = '0; hi_d = hi_q; lo_d = lo_q; ov_d = 1'b0; vld_d = 1'b0;
    if (state == RUN && done) begin
      vld_d = 1'b1; res_d = lo_out; hi_d = hi_out; lo_d = lo_out;
    end else if (fire) begin
      vld_d = ~start;
      if (!bus.op[4]) begin
        res_d = alu_r; ov_d = alu_ov;
      end else begin
        case (bus.op)
          OP_MFHI: res_d = hi_q;
          OP_MFLO: res_d = lo_q;
          OP_MTHI: begin hi_d = bus.a; res_d = bus.a; end
          OP_MTLO: begin lo_d = bus.a; res_d = bus.a; end
          OP_DIV, OP_DIVU: if (dz) begin hi_d = bus.a; lo_d = '1; res_d = '1; end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (fire && is_iter) state_n = dz ? FIX : RUN;
      RUN:     if (done) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; out_valid_q <= 1'b0; zero_q <= 1'b0; ov_q <= 1'b0;
      res_q <= '0; hi_q <= '0; lo_q <= '0;
    end else begin
      state       <= state_n;
      out_valid_q <= vld_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      if (vld_d) begin
        res_q  <= res_d;
        zero_q <= (res_d == '0);
        ov_q   <= ov_d;
      end
    end
  end
endmodule
